// File: rtl/mainfsm_pkg.sv
// Shared state encodings, datapath select encodings and the control bundle
// for the multicycle ARM main FSM.
package mainfsm_pkg;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] UNKNOWN  = 4'd10;

  localparam logic [1:0] SRCA_RN    = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALU    = 1'b1;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Purely combinational decode of the main FSM state into datapath controls.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    // NOTE: assigning a full default before the case keeps every field driven on every path, so no latch is inferred.
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.adr_src    = ADR_PC;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.next_pc    = 1'b1;
      end
      DECODE: begin
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      MEMRD: begin
        ctrl_o.adr_src    = ADR_ALU;
        ctrl_o.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl_o.adr_src    = ADR_ALU;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.mem_w      = 1'b1;
      end
      EXECUTER: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_RM;
        ctrl_o.alu_op    = 1'b1;
      end
      EXECUTEI: begin
        ctrl_o.alu_src_a = SRCA_RN;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b1;
      end
      ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_w      = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alu_src_a  = SRCA_RN;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.branch     = 1'b1;
      end
      UNKNOWN: ctrl_o.illegal = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Moore main state machine of the multicycle ARM controller.
// Define MAINFSM_WAIT_EN to stall FETCH/MEMRD/MEMWR on MemReady=0.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal
);

  logic [STATE_W-1:0] state_q, state_d;
  ctrl_t              dec_ctrl, out_ctrl;
  logic               mem_ok;

`ifdef MAINFSM_WAIT_EN
  assign mem_ok = MemReady;
`else
  logic unused_memready;
  assign unused_memready = MemReady;
  assign mem_ok          = 1'b1;
`endif

  // NOTE: reset is synchronous here, so it lives inside the clocked block; state uses <= so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ok ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = mem_ok ? MEMWB : MEMRD;
      MEMWB:    state_d = FETCH;
      MEMWR:    state_d = mem_ok ? FETCH : MEMWR;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      UNKNOWN:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (dec_ctrl)
  );

  // Reset masks the decode so no strobe escapes while the state is reloading.
  always_comb begin
    out_ctrl = reset ? '0 : dec_ctrl;
  end

  assign IRWrite   = out_ctrl.ir_write;
  assign AdrSrc    = out_ctrl.adr_src;
  assign ALUSrcA   = out_ctrl.alu_src_a;
  assign ALUSrcB   = out_ctrl.alu_src_b;
  assign ResultSrc = out_ctrl.result_src;
  assign ALUOp     = out_ctrl.alu_op;
  assign NextPC    = out_ctrl.next_pc;
  assign RegW      = out_ctrl.reg_w;
  assign MemW      = out_ctrl.mem_w;
  assign Branch    = out_ctrl.branch;
  assign Illegal   = out_ctrl.illegal;

endmodule

// File: doc/mainfsm.md
Name: mainfsm

Overview:
Moore main state machine for the multicycle ARM controller. It sequences fetch, decode, execute, memory and writeback over several cycles per instruction. It drives the datapath mux selects and the unconditioned write strobes (NextPC, RegW, MemW, Branch) consumed by condlogic and the PC logic. It sits beside decode/condlogic inside the controller.

Parameters:
- STATE_W, 4, width of the state register (must hold 11 states).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Op  in  2  instruction bits [27:26]
- Funct  in  6  instruction bits [25:20]; Funct[5]=I (immediate), Funct[0]=L (load)
- MemReady  in  1  memory handshake; used only when MAINFSM_WAIT_EN is defined, otherwise ignored
- IRWrite  out  1  instruction register load enable
- AdrSrc  out  1  memory address select: 0=PC, 1=ALU result
- ALUSrcA  out  2  ALU A select: 00=Rn, 01=PC
- ALUSrcB  out  2  ALU B select: 00=Rm, 01=ExtImm, 10=constant 4
- ResultSrc  out  2  result select: 00=ALUOut, 01=ReadData, 10=ALUResult
- ALUOp  out  1  1 = ALU decoder uses Funct, 0 = ADD
- NextPC  out  1  unconditional PC write (fetch increment)
- RegW  out  1  register write request, before condition gating
- MemW  out  1  memory write request, before condition gating
- Branch  out  1  branch request, before condition gating
- Illegal  out  1  one-cycle pulse in the UNKNOWN state

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- While reset=1, the state register loads FETCH at each rising edge.
- While reset=1, IRWrite, NextPC, RegW, MemW, Branch and Illegal are forced to 0. All selects read 0.
- Output style: all outputs are combinational decodes of the current state only (Moore). Each state lasts exactly one cycle unless stalled.
- States and outputs (unlisted outputs are 0):
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1.
  - UNKNOWN: Illegal=1.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 and Funct[5]=0 -> EXECUTER; Op=00 and Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - UNKNOWN -> FETCH.
  - Unused encodings -> FETCH on the next edge.
- Cycles per instruction: LDR 5, STR 4, data-processing 4, B 3, illegal 3.
- Op and Funct are sampled only in DECODE and MEMADR; they must come from the IR, stable after FETCH.
- Reset mid-instruction: the state returns to FETCH at the next edge with no partial write strobe. A MemW that was already asserted in MEMWR is dropped in the reset cycle.
- Condition gating is not done here; condlogic gates RegW, MemW and Branch with CondExDelayed.

Optional Feature:
- Macro: MAINFSM_WAIT_EN.
- Defined: FETCH, MEMRD and MEMWR hold their state and outputs while MemReady=0, and advance only on an edge where MemReady=1.
  - IRWrite and NextPC stay asserted during a FETCH stall; the downstream registers reload the same values, so the result is unchanged.
  - reset still overrides a stall.
- Undefined: MemReady is ignored and every state lasts exactly one cycle.

Decomposition:
- Shared package mainfsm_pkg holds:
  - the state localparams (FETCH=0 through UNKNOWN=10, 4-bit);
  - the select encodings: SRCB_RM, SRCB_IMM, SRCB_FOUR; RES_ALUOUT, RES_DATA, RES_ALU; ADR_PC, ADR_ALU.
- One natural sub-module, mainfsm_outdec: a purely combinational state-to-control decode. The main module keeps the state register and next-state logic.

Test Plan:
- Reset: hold reset 2 cycles, then release -> first cycle FETCH with IRWrite=1, NextPC=1; all strobes 0 during reset.
- LDR (Op=01, Funct=011001) -> states F, D, MA, MR, MWB, then F; RegW=1 only in cycle 5 with ResultSrc=01.
- STR (Op=01, Funct=011000) -> MemW=1 only in cycle 4, AdrSrc=1; back to FETCH at cycle 5.
- ADD immediate (Op=00, Funct=101000) -> EXECUTEI with ALUSrcB=01, ALUOp=1, then ALUWB RegW=1. Register form (Funct=001000) -> EXECUTER with ALUSrcB=00.
- Branch (Op=10) -> Branch=1 in cycle 3 only. Op=11 -> Illegal=1 in cycle 3, FETCH in cycle 4.
- MAINFSM_WAIT_EN: LDR with MemReady=0 for 3 cycles in MEMRD -> MEMRD held 4 cycles. Also: assert reset during MEMWR -> next state FETCH and MemW=0 in the reset cycle.
